// File: rtl/regfile_pkg.sv
// Shared widths, constants and types for the register file.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package regfile_pkg;

    localparam int RADDR_WIDTH = 5;
    localparam int RDATA_WIDTH = 32;
    localparam int REG_NUM     = 32;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG      = '0;
    localparam logic [RDATA_WIDTH-1:0] ZERO          = '0;
    localparam logic                   WRITE_ENABLE  = 1'b1;
    localparam logic                   WRITE_DISABLE = 1'b0;

    typedef logic [RADDR_WIDTH-1:0] raddr_t;
    typedef logic [RDATA_WIDTH-1:0] rdata_t;
    // Whole storage as one packed vector so it can be handed to the read ports.
    typedef rdata_t [REG_NUM-1:0]   regs_t;

endpackage

// File: rtl/regfile_rport.sv
// One combinational read port: address decode, enable, zero-register and
// optional write-first bypass (REGFILE_BYPASS_EN). Latency: 0 cycles.
// Backpressure: none; output is a pure function of current inputs.
//
// Ports: rst_i forces ZERO; re_i/raddr_i select the entry; regs_i is the
// storage; we_i/waddr_i/wdata_i are the in-flight write (bypass source);
// rdata_o is the read result.
module regfile_rport
    import regfile_pkg::*;
(
    input  logic   rst_i,
    input  logic   re_i,
    input  raddr_t raddr_i,
    input  regs_t  regs_i,
    input  logic   we_i,
    input  raddr_t waddr_i,
    input  rdata_t wdata_i,
    output rdata_t rdata_o
);

`ifdef REGFILE_BYPASS_EN
    // Write-first: a write landing on the address being read this cycle is
    // forwarded so decode sees the value write-back is about to commit.
    logic hit;
    assign hit = we_i && (waddr_i == raddr_i);
`else
    // Read-first: the in-flight write is invisible until the next cycle.
    logic hit;
    logic unused_wr;
    assign hit       = 1'b0;
    assign unused_wr = ^{we_i, waddr_i, wdata_i};
`endif

    always_comb begin
        rdata_o = ZERO;
        if (!rst_i && re_i && (raddr_i != ZERO_REG)) begin
`ifdef REGFILE_BYPASS_EN
            rdata_o = hit ? wdata_i : regs_i[raddr_i];
`else
            rdata_o = hit ? ZERO : regs_i[raddr_i];
`endif
        end
    end

endmodule

// File: rtl/regfile.sv
// 32 x 32 register file, one write port, two independent read ports.
// Latency: reads 0 cycles (combinational); writes visible next cycle.
// Backpressure: none; one write per cycle, never stalls.
//
// Ports: clk_i, rst_i (sync, active-high, clears all entries);
// reg_we_i/reg_waddr_i/reg_wdata_i write-back; rsN_re_i/rsN_raddr_i/
// rsN_rdata_o read ports. Build option: REGFILE_BYPASS_EN selects
// write-first read-during-write (default is read-first).
module regfile
    import regfile_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
    input  logic                   rs1_re_i,
    input  logic [RADDR_WIDTH-1:0] rs1_raddr_i,
    output logic [RDATA_WIDTH-1:0] rs1_rdata_o,
    input  logic                   rs2_re_i,
    input  logic [RADDR_WIDTH-1:0] rs2_raddr_i,
    output logic [RDATA_WIDTH-1:0] rs2_rdata_o
);

    regs_t regs_q;
    regs_t regs_d;
    logic  wr_en;

    // Entry 0 is never a write target, so it stays ZERO from reset onwards.
    assign wr_en = (reg_we_i == WRITE_ENABLE) && (reg_waddr_i != ZERO_REG);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[reg_waddr_i] = reg_wdata_i;
        end
    end

    // Reset wins over a simultaneous write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_rport u_rport1 (
        .rst_i   (rst_i),
        .re_i    (rs1_re_i),
        .raddr_i (rs1_raddr_i),
        .regs_i  (regs_q),
        .we_i    (wr_en),
        .waddr_i (reg_waddr_i),
        .wdata_i (reg_wdata_i),
        .rdata_o (rs1_rdata_o)
    );

    regfile_rport u_rport2 (
        .rst_i   (rst_i),
        .re_i    (rs2_re_i),
        .raddr_i (rs2_raddr_i),
        .regs_i  (regs_q),
        .we_i    (wr_en),
        .waddr_i (reg_waddr_i),
        .wdata_i (reg_wdata_i),
        .rdata_o (rs2_rdata_o)
    );

endmodule

// File: tb/tb_regfile.sv
// Testbench for regfile: vector table, fill/reset sweeps and a random phase.
// Latency: reads checked in the same cycle they are driven.
// Backpressure: none.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  waddr;
    logic        we;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;

    always #5 clk = ~clk;

    regfile dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_waddr_i (waddr),
        .reg_we_i    (we),
        .reg_wdata_i (wdata),
        .rs1_re_i    (re1),
        .rs1_raddr_i (a1),
        .rs1_rdata_o (d1),
        .rs2_re_i    (re2),
        .rs2_raddr_i (a2),
        .rs2_rdata_o (d2)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  a1;
        logic        re2;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [32];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare mid-cycle, then let
    // the rising edge commit and mirror the commit in the reference model.
    task automatic cyc(input vec_t v, input string nm);
        exp_t e;
        @(negedge clk);
        rst = v.rst; we = v.we; waddr = v.wa; wdata = v.wd;
        re1 = v.re1; a1 = v.a1; re2 = v.re2; a2 = v.a2;
        sbq.push_back('{e1: v.e1, e2: v.e2});
        #2;
        e = sbq.pop_front();
        chk({nm, "/rs1"}, d1, e.e1);
        chk({nm, "/rs2"}, d2, e.e2);
        @(posedge clk);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (v.we && v.wa != 5'd0) begin
            model[v.wa] = v.wd;
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [4:0] wa,
                                input logic [31:0] wd, input logic r1, input logic [4:0] x1,
                                input logic r2, input logic [4:0] x2,
                                input logic [31:0] e1, input logic [31:0] e2);
        vec_t v;
        v.rst = r; v.we = w; v.wa = wa; v.wd = wd;
        v.re1 = r1; v.a1 = x1; v.re2 = r2; v.a2 = x2;
        v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    function automatic logic [31:0] predict(input vec_t v, input bit port2);
        logic        re   = port2 ? v.re2 : v.re1;
        logic [4:0]  a    = port2 ? v.a2 : v.a1;
        if (v.rst || !re || a == 5'd0) return 32'h0;
        if (BYP && v.we && v.wa == a) return v.wd;
        return model[a];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        vec_t v;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; a1 = '0; re2 = 1'b0; a2 = '0;

        //          rst we  wa     wd            re1 a1    re2 a2    e1            e2
        tbl[0]  = mk(1, 0, 5'd0, 32'h0,        1, 5'd1, 1, 5'd2, 32'h0,        32'h0);
        tbl[1]  = mk(1, 1, 5'd3, 32'hFFFFFFFF, 1, 5'd3, 1, 5'd3, 32'h0,        32'h0);
        tbl[2]  = mk(0, 0, 5'd0, 32'h0,        1, 5'd3, 1, 5'd1, 32'h0,        32'h0);
        tbl[3]  = mk(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd5, 0, 5'd5, 32'h0,        32'h0);
        tbl[4]  = mk(0, 0, 5'd0, 32'h0,        1, 5'd5, 1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        tbl[5]  = mk(0, 1, 5'd0, 32'h12345678, 1, 5'd0, 1, 5'd0, 32'h0,        32'h0);
        tbl[6]  = mk(0, 0, 5'd0, 32'h0,        1, 5'd0, 0, 5'd5, 32'h0,        32'h0);
        tbl[7]  = mk(0, 1, 5'd7, 32'h1,        1, 5'd5, 0, 5'd0, 32'hDEADBEEF, 32'h0);
        tbl[8]  = mk(0, 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 1, 5'd5,
                     BYP ? 32'hA5A5A5A5 : 32'h1, 32'hDEADBEEF);
        tbl[9]  = mk(0, 0, 5'd0, 32'h0,        1, 5'd7, 1, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[10] = mk(1, 0, 5'd0, 32'h0,        1, 5'd5, 1, 5'd7, 32'h0,        32'h0);
        tbl[11] = mk(0, 0, 5'd0, 32'h0,        1, 5'd5, 1, 5'd7, 32'h0,        32'h0);

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i], $sformatf("vec%0d", i));
        end

        // Fill every register, read them back pairwise, then reset and sweep.
        for (int i = 1; i < 32; i++) begin
            cyc(mk(0, 1, 5'(i), 32'h01010101 * i, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0), "fill");
        end
        for (int i = 1; i < 32; i++) begin
            cyc(mk(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(32 - i),
                   32'h01010101 * i, 32'h01010101 * (32 - i)),
                $sformatf("readback%0d", i));
        end
        cyc(mk(1, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0), "rst2");
        for (int i = 1; i < 32; i++) begin
            cyc(mk(0, 0, 5'd0, 32'h0, 1, 5'(i), 1, 5'(i), 32'h0, 32'h0),
                $sformatf("zero%0d", i));
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            v.rst = ($urandom_range(0, 39) == 0);
            v.we  = $urandom_range(0, 1);
            v.wa  = 5'($urandom_range(0, 31));
            v.wd  = $urandom;
            v.re1 = ($urandom_range(0, 3) != 0);
            v.re2 = ($urandom_range(0, 3) != 0);
            v.a1  = ($urandom_range(0, 3) == 0) ? v.wa : 5'($urandom_range(0, 31));
            v.a2  = ($urandom_range(0, 3) == 0) ? v.wa : 5'($urandom_range(0, 31));
            v.e1  = predict(v, 1'b0);
            v.e2  = predict(v, 1'b1);
            cyc(v, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
